md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5, number of cycles busy stays high after a mult/multu start.
REQ-002 Parameter DIV_CYCLES, default 10, number of cycles busy stays high after a div/divu start.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage instruction is an MD-unit operation this cycle.
REQ-006 op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved.
REQ-007 rs_val  input  32  forwarded rs operand (dividend or multiplicand; mthi/mtlo source).
REQ-008 rt_val  input  32  forwarded rt operand (divisor or multiplier).
REQ-009 D_md_use  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 stall  output  1  pipeline stall request to the hazard unit (combinational).
REQ-012 hi  output  32  architectural HI register.
REQ-013 lo  output  32  architectural LO register.

Function
REQ-014 The block SHALL have two states: IDLE and BUSY, plus a countdown counter wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE with start=1 and op in {0,1}: SHALL latch the operands, load the counter with MULT_CYCLES, and enter BUSY at that edge.
REQ-016 In IDLE with start=1 and op in {2,3}: SHALL latch the operands, load the counter with DIV_CYCLES, and enter BUSY.
REQ-017 busy SHALL be 1 for exactly N consecutive cycles following the start edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-018 At the edge ending the Nth busy cycle: hi/lo SHALL take the result, busy SHALL fall, and the state SHALL return to IDLE.
REQ-019 mult: {hi,lo} = signed 32x32 -> 64-bit product.
REQ-020 multu: {hi,lo} = the unsigned product.
REQ-021 div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-022 divu: lo = unsigned quotient; hi = unsigned remainder.
REQ-023 Divisor = 0 on div/divu: the operation SHALL run full DIV_CYCLES, and hi/lo SHALL remain unchanged at completion.
REQ-024 div of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-025 mthi/mtlo with start=1 in IDLE: SHALL write rs_val into hi/lo at that edge, with no busy cycle.
REQ-026 start=1 while BUSY (any op) SHALL be ignored; in-flight operands and the counter SHALL be unaffected.
REQ-027 op 6-7 with start=1 SHALL have no effect.
REQ-028 Operand changes during BUSY SHALL NOT affect the result (operands are latched at start).
REQ-029 stall = D_md_use & (busy | (start & op in {0,1,2,3})).
REQ-030 stall SHALL NOT depend on the registered state except through busy.
REQ-031 hi/lo SHALL be readable every cycle; during BUSY they SHALL hold their prior values.

Reset
REQ-032 On reset low, asynchronously and regardless of clk: state = IDLE, counter = 0, busy = 0, hi = 0, lo = 0.
REQ-033 Reset asserted mid-operation SHALL abort the operation with no hi/lo update.
REQ-034 After reset release, the first rising edge SHALL accept start normally.
REQ-035 stall SHALL be 0 under reset unless start & D_md_use imply otherwise per REQ-029.

Verification
REQ-036 mult rs=0xFFFFFFFE, rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 cycles.
REQ-038 div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 divu with rt=0 after mthi 0x1234 / mtlo 0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
REQ-040 mult start, then D_md_use=1 held -> stall=1 on the start cycle and all 5 busy cycles, 0 on the cycle after; a second start during busy is ignored.
REQ-041 div started, reset pulsed low at busy cycle 4 -> busy=0, hi=lo=0 immediately; no later update.

Source files
------------

// File: rtl/md_ctrl_if.sv
// Operand/result bundle between the E-stage issue logic and the multiply/divide unit.
// The master drives the operation request; the slave returns busy, stall and HI/LO.
interface md_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        D_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val, D_md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, D_md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide unit with HI/LO: mult/div hold busy for MULT_CYCLES/DIV_CYCLES, mthi/mtlo write in one edge.
// New starts are ignored while busy; stall holds the D-stage MD instruction until the unit frees up.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_ctrl_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  // Result datapath works only on latched operands, so live input changes cannot leak in.
  logic [63:0] mul_a, mul_b, prod;
  logic        div_signed;
  logic [31:0] dvd, dvs_mag, dvs, uq, ur, quot, rem;

  always_comb begin
    mul_a = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
    mul_b = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
    prod  = mul_a * mul_b;
  end

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 naturally.
  always_comb begin
    div_signed = (op_q == 2'd2);
    dvd        = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    dvs_mag    = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    dvs        = (b_q == 32'd0) ? 32'd1 : dvs_mag;
    uq         = dvd / dvs;
    ur         = dvd % dvs;
    quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    rem        = (div_signed && a_q[31]) ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              op_d    = bus.op[1:0];
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = BUSY;
            end
            3'd2, 3'd3: begin
              op_d    = bus.op[1:0];
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = BUSY;
            end
            3'd4:    hi_d = bus.rs_val;
            3'd5:    lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!op_q[1]) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy  = (state_q == BUSY);
  assign bus.stall = bus.D_md_use & (bus.busy | (bus.start & ~bus.op[2]));
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: mult/multu/div/divu results, busy length, stall, ignored starts, reset abort.
module tb_md_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_ctrl_if bus ();

  md_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.start  = s;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
  endtask

  // Checks busy and held HI/LO for n cycles, then busy low afterwards.
  task automatic run_busy(input string tag, input int n, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
      check({tag, "_hold_hi"}, bus.hi, hold_hi);
      check({tag, "_hold_lo"}, bus.lo, hold_lo);
      step();
    end
    check({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset        = 1'b0;
    bus.D_md_use = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    #2;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    bus.D_md_use = 1'b1;
    drive(1'b1, 3'd0, 32'd1, 32'd1);
    check("rst_stall_mult_start", {31'b0, bus.stall}, 32'd1);
    drive(1'b1, 3'd4, 32'd1, 32'd1);
    check("rst_stall_mthi", {31'b0, bus.stall}, 32'd0);
    bus.D_md_use = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("idle_busy", {31'b0, bus.busy}, 32'd0);

    // mult with stall held, operand change and a second start during busy
    bus.D_md_use = 1'b1;
    drive(1'b1, 3'd0, 32'hFFFF_FFFE, 32'd3);
    check("mult_stall_start", {31'b0, bus.stall}, 32'd1);
    check("mult_busy_pre", {31'b0, bus.busy}, 32'd0);
    step();
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) drive(1'b1, 3'd2, 32'd5, 32'd1);
      else        drive(1'b0, 3'd0, 32'hDEAD_BEEF, 32'h1234_5678);
      check("mult_busy", {31'b0, bus.busy}, 32'd1);
      check("mult_stall", {31'b0, bus.stall}, 32'd1);
      check("mult_hold_hi", bus.hi, 32'd0);
      check("mult_hold_lo", bus.lo, 32'd0);
      step();
    end
    check("mult_busy_end", {31'b0, bus.busy}, 32'd0);
    check("mult_stall_end", {31'b0, bus.stall}, 32'd0);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);
    bus.D_md_use = 1'b0;

    drive(1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    check("multu_hi", bus.hi, 32'h0000_0002);
    check("multu_lo", bus.lo, 32'hFFFF_FFFA);

    drive(1'b1, 3'd4, 32'h0000_1234, 32'd0);
    step();
    check("mthi_busy", {31'b0, bus.busy}, 32'd0);
    check("mthi_hi", bus.hi, 32'h0000_1234);
    check("mthi_lo", bus.lo, 32'hFFFF_FFFA);
    drive(1'b1, 3'd5, 32'h0000_5678, 32'd0);
    step();
    check("mtlo_lo", bus.lo, 32'h0000_5678);
    check("mtlo_hi", bus.hi, 32'h0000_1234);

    drive(1'b1, 3'd3, 32'h0000_9999, 32'd0);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("divu0", 10, 32'h0000_1234, 32'h0000_5678);
    check("divu0_hi", bus.hi, 32'h0000_1234);
    check("divu0_lo", bus.lo, 32'h0000_5678);

    drive(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("div_m7", 10, 32'h0000_1234, 32'h0000_5678);
    check("div_m7_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_m7_hi", bus.hi, 32'hFFFF_FFFF);

    drive(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("div_ovf", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0000_0000);

    drive(1'b1, 3'd3, 32'd100, 32'd7);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("divu", 10, 32'h0000_0000, 32'h8000_0000);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);

    drive(1'b1, 3'd2, 32'd7, 32'hFFFF_FFFE);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("div_7m2", 10, 32'd2, 32'd14);
    check("div_7m2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_7m2_hi", bus.hi, 32'd1);

    drive(1'b1, 3'd6, 32'h0000_AAAA, 32'h0000_BBBB);
    step();
    drive(1'b1, 3'd7, 32'h0000_AAAA, 32'h0000_BBBB);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("rsvd_busy", {31'b0, bus.busy}, 32'd0);
    check("rsvd_hi", bus.hi, 32'd1);
    check("rsvd_lo", bus.lo, 32'hFFFF_FFFD);

    // reset in busy cycle 4 of a divide
    drive(1'b1, 3'd4, 32'h0000_AAAA, 32'd0);
    step();
    drive(1'b1, 3'd2, 32'd100, 32'd7);
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    step();
    step();
    step();
    check("abort_busy_pre", {31'b0, bus.busy}, 32'd1);
    check("abort_hi_pre", bus.hi, 32'h0000_AAAA);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    step();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("abort_late_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_late_hi", bus.hi, 32'd0);
    check("abort_late_lo", bus.lo, 32'd0);

    // start presented across reset release is taken on the first edge
    reset = 1'b0;
    #1;
    drive(1'b1, 3'd1, 32'd6, 32'd7);
    @(negedge clk);
    reset = 1'b1;
    step();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    run_busy("post_rst", 5, 32'd0, 32'd0);
    check("post_rst_hi", bus.hi, 32'd0);
    check("post_rst_lo", bus.lo, 32'd42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
